// File: rtl/rx_ltssm_os_ctrl_pkg.sv
// Shared symbol constants, state and ordered-set type encodings for the RX LTSSM ordered-set controller.
package rx_ltssm_pkg;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam logic [7:0] SKP_SYM  = 8'h1C;
  localparam logic [7:0] EIO      = 8'h7C;
  localparam logic [7:0] PAD      = 8'hF7;

  localparam logic [7:0] G3_TS1   = 8'h1E;
  localparam logic [7:0] G3_TS2   = 8'h2D;
  localparam logic [7:0] G3_SKP   = 8'hAA;
  localparam logic [7:0] G3_EIOS  = 8'h66;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    POLL_ACTIVE   = 3'd1,
    POLL_CONFIG   = 3'd2,
    CFG_LINKWIDTH = 3'd3,
    CFG_COMPLETE  = 3'd4,
    L0            = 3'd5
  } ltssm_state_t;

  typedef enum logic [2:0] {
    OS_OTHER = 3'd0,
    OS_TS1   = 3'd1,
    OS_TS2   = 3'd2,
    OS_SKP   = 3'd3,
    OS_EIOS  = 3'd4
  } os_type_t;

  function automatic logic [7:0] os_sym(input logic [127:0] d, input logic [3:0] k);
    return d[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rx_ltssm_os_ctrl_classifier.sv
// Combinational ordered-set classifier; 8b/10b framing for gen 1/2, 128b/130b identifiers for gen 3+.
module rx_os_classifier
  import rx_ltssm_pkg::*;
(
  input  logic [127:0] osData,
  input  logic [2:0]   gen,
  output os_type_t     osType
);

  logic [7:0] sym0, sym1, sym6;

  assign sym0 = os_sym(osData, 4'd0);
  assign sym1 = os_sym(osData, 4'd1);
  assign sym6 = os_sym(osData, 4'd6);

  always_comb begin
    osType = OS_OTHER;
    if (gen >= 3'd3) begin
      if (sym0 == G3_TS1)                  osType = OS_TS1;
      else if (sym0 == G3_TS2)             osType = OS_TS2;
      else if (sym0 == G3_SKP)             osType = OS_SKP;
      else if (osData == {16{G3_EIOS}})    osType = OS_EIOS;
    end else if (sym0 == COM) begin
      // TS identifiers take priority so a link number that aliases SKP/EIO still reads as a TS
      if (sym6 == TS1_ID)                  osType = OS_TS1;
      else if (sym6 == TS2_ID)             osType = OS_TS2;
      else if (sym1 == SKP_SYM)            osType = OS_SKP;
      else if (sym1 == EIO)                osType = OS_EIOS;
    end
  end

endmodule

// File: rtl/rx_ltssm_os.sv
// Polling/Configuration substate sequencer driven by decoded ordered sets; all outputs registered,
// one cycle from the sampling edge. No backpressure: every valid ordered set is consumed.
module rx_ltssm_os_ctrl
  import rx_ltssm_pkg::*;
#(
  parameter int TS_CNT_POLL    = 8,
  parameter int TS_CNT_CFG     = 2,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int TMR_W          = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   detectedLanes,
  input  logic [2:0]   gen,
  input  logic         osValid,
  input  logic [127:0] osData,
  output logic         decoderEnable,
  output logic [4:0]   decoderLanes,
  output logic [2:0]   decoderGen,
  output logic [2:0]   state,
  output logic [3:0]   tsCount,
  output logic [7:0]   linkNum,
  output logic [4:0]   laneNum,
  output logic         linkUp,
  output logic         timeoutPulse,
  output logic         eiosSeen
);

  ltssm_state_t     cur_state, nxt_state;
  os_type_t         os_type, last_type;
  logic [39:0]      last_body;
  logic [TMR_W-1:0] timer;
  logic             training, is_target, same_ts, cnt_hit, timeout;
  logic [3:0]       cnt_nxt, cnt_thr, ts_count_d;
  logic             enable_d, linkup_d, timeout_d, eios_d, capture;
  logic [4:0]       lanes_legal;

  rx_os_classifier u_classifier (
    .osData (osData),
    .gen    (decoderGen),
    .osType (os_type)
  );

  assign state    = cur_state;
  assign training = cur_state inside {POLL_ACTIVE, POLL_CONFIG, CFG_LINKWIDTH, CFG_COMPLETE};
  assign timeout  = training && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign cnt_thr  = (cur_state inside {POLL_ACTIVE, POLL_CONFIG}) ? 4'(TS_CNT_POLL) : 4'(TS_CNT_CFG);
  // Type is part of the match so a TS1->TS2 switch in POLL_ACTIVE restarts the run
  assign same_ts  = (tsCount != 4'd0) && (os_type == last_type) && (osData[47:8] == last_body);
  assign cnt_hit  = osValid && is_target && (cnt_nxt == cnt_thr);

  always_comb begin
    is_target = 1'b0;
    case (cur_state)
      POLL_ACTIVE:   is_target = (os_type == OS_TS1) || (os_type == OS_TS2);
      POLL_CONFIG:   is_target = (os_type == OS_TS2);
      CFG_LINKWIDTH: is_target = (os_type == OS_TS1) && (os_sym(osData, 4'd1) != PAD);
      CFG_COMPLETE:  is_target = (os_type == OS_TS2) && (os_sym(osData, 4'd2) != PAD);
      default:       is_target = 1'b0;
    endcase
  end

  always_comb begin
    cnt_nxt = tsCount;
    if (osValid && (os_type != OS_SKP)) begin
      if (!is_target)
        cnt_nxt = 4'd0;
      else if (!same_ts)
        cnt_nxt = 4'd1;
      else if (tsCount != 4'd15)
        cnt_nxt = tsCount + 4'd1;
    end
  end

  always_comb begin
    case (detectedLanes)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_legal = detectedLanes;
      default:                       lanes_legal = 5'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:          if (start)   nxt_state = POLL_ACTIVE;
      POLL_ACTIVE:   if (cnt_hit) nxt_state = POLL_CONFIG;
      POLL_CONFIG:   if (cnt_hit) nxt_state = CFG_LINKWIDTH;
      CFG_LINKWIDTH: if (cnt_hit) nxt_state = CFG_COMPLETE;
      CFG_COMPLETE:  if (cnt_hit) nxt_state = L0;
      L0: begin
        if (osValid && (os_type == OS_EIOS))     nxt_state = IDLE;
        else if (osValid && (os_type == OS_TS1)) nxt_state = CFG_LINKWIDTH;
      end
      default:                    nxt_state = IDLE;
    endcase
    if (timeout) nxt_state = IDLE;
  end

  always_comb begin
    ts_count_d = ((nxt_state != cur_state) || !training) ? 4'd0 : cnt_nxt;
    enable_d   = (nxt_state != IDLE);
    linkup_d   = (nxt_state == L0);
    timeout_d  = timeout;
    eios_d     = (cur_state == L0) && osValid && (os_type == OS_EIOS);
    capture    = (cur_state == CFG_COMPLETE) && cnt_hit && !timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tsCount       <= 4'd0;
      decoderEnable <= 1'b0;
      linkUp        <= 1'b0;
      timeoutPulse  <= 1'b0;
      eiosSeen      <= 1'b0;
      decoderLanes  <= 5'd0;
      decoderGen    <= 3'd0;
      linkNum       <= 8'd0;
      laneNum       <= 5'd0;
    end else begin
      tsCount       <= ts_count_d;
      decoderEnable <= enable_d;
      linkUp        <= linkup_d;
      timeoutPulse  <= timeout_d;
      eiosSeen      <= eios_d;
      if ((cur_state == IDLE) && start) begin
        decoderLanes <= lanes_legal;
        decoderGen   <= gen;
      end
      if (capture) begin
        linkNum <= osData[15:8];
        laneNum <= osData[20:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      last_type <= OS_OTHER;
      last_body <= '0;
    end else begin
      timer <= ((nxt_state != cur_state) || !training) ? '0 : timer + 1'b1;
      if (osValid && is_target) begin
        last_type <= os_type;
        last_body <= osData[47:8];
      end
    end
  end

endmodule

// File: tb/tb_rx_ltssm_os_ctrl.sv
// Directed plus randomized bench for rx_ltssm_os_ctrl against a per-ordered-set behavioural model.
module tb_rx_ltssm_os_ctrl;

  localparam int TO  = 50;
  localparam int TSP = 8;
  localparam int TSC = 2;

  logic         clk = 1'b0;
  logic         reset, start, osValid;
  logic [4:0]   detectedLanes;
  logic [2:0]   gen;
  logic [127:0] osData;
  logic         decoderEnable, linkUp, timeoutPulse, eiosSeen;
  logic [4:0]   decoderLanes, laneNum;
  logic [2:0]   decoderGen, state;
  logic [3:0]   tsCount;
  logic [7:0]   linkNum;

  rx_ltssm_os_ctrl #(
    .TS_CNT_POLL(TSP), .TS_CNT_CFG(TSC), .TIMEOUT_CYCLES(TO), .TMR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .detectedLanes(detectedLanes), .gen(gen),
    .osValid(osValid), .osData(osData), .decoderEnable(decoderEnable),
    .decoderLanes(decoderLanes), .decoderGen(decoderGen), .state(state), .tsCount(tsCount),
    .linkNum(linkNum), .laneNum(laneNum), .linkUp(linkUp), .timeoutPulse(timeoutPulse),
    .eiosSeen(eiosSeen)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 idle, 1 poll-active, 2 poll-config, 3 cfg-linkwidth, 4 cfg-complete, 5 L0
  int        m_state = 0, m_cnt = 0, m_age = 0, m_last_ty = 0;
  bit [39:0] m_last = '0;
  bit [4:0]  m_lanes = '0, m_lane = '0;
  bit [2:0]  m_gen = '0;
  bit [7:0]  m_link = '0;
  bit        m_tp = 1'b0, m_eios = 1'b0;

  // 0 other, 1 TS1, 2 TS2, 3 SKP, 4 EIOS
  function automatic int classify(bit [127:0] d, bit [2:0] g);
    bit [7:0] s0, s1, s6;
    s0 = d[7:0]; s1 = d[15:8]; s6 = d[55:48];
    if (g >= 3) begin
      if (s0 == 8'h1E) return 1;
      if (s0 == 8'h2D) return 2;
      if (s0 == 8'hAA) return 3;
      if (d == {16{8'h66}}) return 4;
      return 0;
    end
    if (s0 != 8'hBC) return 0;
    if (s6 == 8'h4A) return 1;
    if (s6 == 8'h45) return 2;
    if (s1 == 8'h1C) return 3;
    if (s1 == 8'h7C) return 4;
    return 0;
  endfunction

  task automatic model_step(bit rst, bit st, bit [4:0] dl, bit [2:0] g, bit v, bit [127:0] d);
    int  ty, nst, thr;
    bit  tgt, tmo;
    m_tp = 1'b0; m_eios = 1'b0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_age = 0; m_lanes = '0; m_gen = '0; m_link = '0; m_lane = '0;
      return;
    end
    nst = m_state;
    ty  = v ? classify(d, m_gen) : -1;
    if (m_state == 0) begin
      if (st) begin
        nst = 1;
        m_lanes = (dl inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) ? dl : 5'd1;
        m_gen = g;
      end
    end else if (m_state == 5) begin
      if (ty == 4) begin nst = 0; m_eios = 1'b1; end
      else if (ty == 1) nst = 3;
    end else begin
      tmo = (m_age == TO - 1);
      tgt = (m_state == 1 && (ty == 1 || ty == 2)) || (m_state == 2 && ty == 2) ||
            (m_state == 3 && ty == 1 && d[15:8] != 8'hF7) ||
            (m_state == 4 && ty == 2 && d[23:16] != 8'hF7);
      if (tgt) begin
        if (m_cnt > 0 && ty == m_last_ty && d[47:8] == m_last) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else m_cnt = 1;
        m_last_ty = ty; m_last = d[47:8];
        thr = (m_state <= 2) ? TSP : TSC;
        if (m_cnt == thr && !tmo) begin
          nst = m_state + 1;
          if (m_state == 4) begin m_link = d[15:8]; m_lane = d[20:16]; end
        end
      end else if (v && ty != 3) begin
        m_cnt = 0;
      end
      if (tmo) begin nst = 0; m_tp = 1'b1; end
    end
    if (nst != m_state) begin m_cnt = 0; m_age = 0; end
    else if (m_state >= 1 && m_state <= 4) m_age++;
    m_state = nst;
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",     128'(state),         128'(m_state));
    chk("tsCount",   128'(tsCount),       128'(m_cnt));
    chk("enable",    128'(decoderEnable), 128'(m_state != 0));
    chk("linkUp",    128'(linkUp),        128'(m_state == 5));
    chk("lanes",     128'(decoderLanes),  128'(m_lanes));
    chk("gen",       128'(decoderGen),    128'(m_gen));
    chk("linkNum",   128'(linkNum),       128'(m_link));
    chk("laneNum",   128'(laneNum),       128'(m_lane));
    chk("timeout",   128'(timeoutPulse),  128'(m_tp));
    chk("eiosSeen",  128'(eiosSeen),      128'(m_eios));
  endtask

  task automatic cyc(bit v, bit [127:0] d);
    osValid = v; osData = d;
    model_step(reset, start, detectedLanes, gen, v, d);
    @(posedge clk); #1;
    check_all();
    start = 1'b0;
  endtask

  function automatic bit [127:0] mk(bit g3, int kind, bit [7:0] s1, bit [7:0] s2, bit [7:0] s4);
    bit [127:0] d;
    bit [7:0]   id;
    id = (kind == 2) ? 8'h45 : 8'h4A;
    d  = '0;
    case (kind)
      1, 2: begin
        for (int k = 6; k < 16; k++) d[8*k +: 8] = id;
        d[15:8] = s1; d[23:16] = s2; d[31:24] = 8'h10; d[39:32] = s4; d[47:40] = 8'h30;
        d[7:0]  = g3 ? ((kind == 1) ? 8'h1E : 8'h2D) : 8'hBC;
      end
      3:       d = g3 ? {16{8'hAA}} : {{15{8'h1C}}, 8'hBC};
      4:       d = g3 ? {16{8'h66}} : {{15{8'h7C}}, 8'hBC};
      default: d = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return d;
  endfunction

  task automatic train_to_l0(bit g3);
    repeat (TSP) cyc(1'b1, mk(g3, 1, 8'h05, 8'h03, 8'h20));
    repeat (TSP) cyc(1'b1, mk(g3, 2, 8'h05, 8'h03, 8'h20));
    repeat (TSC) cyc(1'b1, mk(g3, 1, 8'h05, 8'h03, 8'h20));
    repeat (TSC) cyc(1'b1, mk(g3, 2, 8'h05, 8'h03, 8'h20));
  endtask

  initial begin
    bit [127:0] d1, d2, d3;
    bit [7:0]   r1, r2, r4, ks1, ks2, ks4;
    int         kind;

    reset = 1'b1; start = 1'b0; detectedLanes = '0; gen = '0; osValid = 1'b0; osData = '0;
    cyc(1'b0, '0); cyc(1'b0, '0);
    reset = 1'b0;

    // gen1 x2: eight identical TS1 leave POLL_ACTIVE
    gen = 3'd1; detectedLanes = 5'd2; start = 1'b1;
    cyc(1'b0, '0);
    r1 = 8'($urandom); r2 = 8'($urandom); r4 = 8'($urandom);
    d1 = mk(1'b0, 1, r1, r2, r4);
    repeat (TSP) cyc(1'b1, d1);
    chk("pa_exit_state", 128'(state), 128'(2));
    chk("pa_exit_cnt",   128'(tsCount), 128'(0));
    chk("pa_lanes",      128'(decoderLanes), 128'(2));

    // POLL_CONFIG: content change restarts at 1, SKP leaves the count alone
    d2 = mk(1'b0, 2, r1, r2, r4);
    d3 = mk(1'b0, 2, r1, r2, r4 ^ 8'h01);
    repeat (4) cyc(1'b1, d2);
    cyc(1'b1, d3);
    chk("pc_restart", 128'(tsCount), 128'(1));
    repeat (4) cyc(1'b1, d3);
    cyc(1'b1, mk(1'b0, 3, 8'h0, 8'h0, 8'h0));
    chk("pc_skp_cnt", 128'(tsCount), 128'(5));
    repeat (2) cyc(1'b1, d3);
    chk("pc_hold", 128'(state), 128'(2));
    cyc(1'b1, d3);
    chk("pc_exit", 128'(state), 128'(3));

    // CFG_LINKWIDTH: PAD link number is not a target
    cyc(1'b1, mk(1'b0, 1, 8'h05, 8'h03, 8'h20));
    cyc(1'b1, mk(1'b0, 1, 8'hF7, 8'h03, 8'h20));
    chk("lw_pad_cnt", 128'(tsCount), 128'(0));
    repeat (TSC) cyc(1'b1, mk(1'b0, 1, 8'h05, 8'h03, 8'h20));
    chk("lw_exit", 128'(state), 128'(4));
    repeat (TSC) cyc(1'b1, mk(1'b0, 2, 8'h05, 8'h03, 8'h20));
    chk("l0_linkup", 128'(linkUp), 128'(1));
    chk("l0_linknum", 128'(linkNum), 128'(8'h05));
    chk("l0_lanenum", 128'(laneNum), 128'(3));

    // L0: TS1 drops to CFG_LINKWIDTH, then EIOS returns to IDLE
    cyc(1'b1, mk(1'b0, 1, 8'h05, 8'h03, 8'h20));
    chk("l0_ts1", 128'(state), 128'(3));
    repeat (TSC) cyc(1'b1, mk(1'b0, 1, 8'h05, 8'h03, 8'h20));
    repeat (TSC) cyc(1'b1, mk(1'b0, 2, 8'h05, 8'h03, 8'h20));
    cyc(1'b1, mk(1'b0, 4, 8'h0, 8'h0, 8'h0));
    chk("eios_pulse", 128'(eiosSeen), 128'(1));
    cyc(1'b0, '0);
    chk("eios_clear", 128'(eiosSeen), 128'(0));

    // Timeout with no ordered sets
    start = 1'b1;
    cyc(1'b0, '0);
    repeat (TO - 1) cyc(1'b0, '0);
    chk("to_before", 128'(state), 128'(1));
    cyc(1'b0, '0);
    chk("to_pulse", 128'(timeoutPulse), 128'(1));
    chk("to_idle", 128'(state), 128'(0));
    cyc(1'b0, '0);
    chk("to_clear", 128'(timeoutPulse), 128'(0));

    // gen3 with illegal lane count, all-66 EIOS in L0
    gen = 3'd3; detectedLanes = 5'd7; start = 1'b1;
    cyc(1'b0, '0);
    chk("g3_lanes", 128'(decoderLanes), 128'(1));
    train_to_l0(1'b1);
    chk("g3_l0", 128'(state), 128'(5));
    cyc(1'b1, mk(1'b1, 4, 8'h0, 8'h0, 8'h0));
    chk("g3_eios", 128'(eiosSeen), 128'(1));

    // Reset in CFG_COMPLETE with a partial count
    gen = 3'd1; detectedLanes = 5'd4; start = 1'b1;
    cyc(1'b0, '0);
    repeat (TSP) cyc(1'b1, mk(1'b0, 1, 8'h05, 8'h03, 8'h20));
    repeat (TSP) cyc(1'b1, mk(1'b0, 2, 8'h05, 8'h03, 8'h20));
    repeat (TSC) cyc(1'b1, mk(1'b0, 1, 8'h05, 8'h03, 8'h20));
    cyc(1'b1, mk(1'b0, 2, 8'h05, 8'h03, 8'h20));
    chk("cc_partial", 128'(tsCount), 128'(1));
    reset = 1'b1;
    cyc(1'b1, mk(1'b0, 2, 8'h05, 8'h03, 8'h20));
    reset = 1'b0;
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_lanes", 128'(decoderLanes), 128'(0));
    chk("rst_link",  128'(linkNum), 128'(0));

    // Randomized: sticky ordered sets so runs long enough to train appear
    kind = 1; ks1 = 8'h05; ks2 = 8'h03; ks4 = 8'h20;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) begin
        gen = 3'($urandom_range(1, 5));
        detectedLanes = 5'($urandom);
      end
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 19))
          0:                kind = 0;
          1:                kind = 4;
          2, 3:             kind = 3;
          4, 5, 6, 7, 8, 9: kind = 1;
          default:          kind = 2;
        endcase
        ks1 = ($urandom_range(0, 9) == 0) ? 8'hF7 : 8'h05;
        ks2 = ($urandom_range(0, 9) == 0) ? 8'hF7 : 8'h03;
        ks4 = ($urandom_range(0, 9) == 0) ? 8'h21 : 8'h20;
      end
      cyc($urandom_range(0, 3) != 0, mk(gen >= 3'd3, kind, ks1, ks2, ks4));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
